// File: rtl/psum_accumulator_if.sv
// Handshake, configuration and status bundle between the PE-side driver and the
// partial-sum accumulator.
interface psum_accumulator_if #(
  parameter int unsigned PSUM_W = 20,
  parameter int unsigned OUT_W  = 8
);
  logic                     start;
  logic [7:0]               cfg_num_tiles;
  logic [15:0]              cfg_num_pixels;
  logic [4:0]               cfg_shift;
  logic                     cfg_relu;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PSUM_W-1:0] pe_ofm0;
  logic signed [PSUM_W-1:0] pe_ofm1;
  logic                     out_valid;
  logic                     out_ready;
  logic [2*OUT_W-1:0]       out_data;
  logic                     busy;
  logic                     done;

  modport master (
    output start, cfg_num_tiles, cfg_num_pixels, cfg_shift, cfg_relu,
    output in_valid, pe_ofm0, pe_ofm1, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, cfg_num_tiles, cfg_num_pixels, cfg_shift, cfg_relu,
    input  in_valid, pe_ofm0, pe_ofm1, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates two lanes of PE partial sums over channel tiles, requantizes each
// finished pixel to int8 and queues it in a first-word-fall-through output FIFO.
module psum_accumulator #(
  parameter int unsigned PSUM_W     = 20,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  psum_accumulator_if.slave     bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic signed [ACC_W:0] SatMax = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e                  r_state, w_state_next;
  logic [7:0]              r_num_tiles, r_tile_cnt;
  logic [15:0]             r_num_pixels, r_pix_cnt;
  logic [4:0]              r_shift;
  logic                    r_relu;
  logic signed [ACC_W-1:0] r_acc0, r_acc1;
  logic                    r_stage_valid;
  logic [2*OUT_W-1:0]      r_stage_data;
  logic [2*OUT_W-1:0]      r_fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]         r_count;
  logic                    r_done;

  logic                    w_in_ready, w_out_valid, w_accept, w_push, w_pop;
  logic                    w_last_tile, w_last_pix;
  logic [CntW-1:0]         w_occupancy;
  logic signed [ACC_W-1:0] w_ext0, w_ext1, w_sum0, w_sum1;

  // Round half up, optional ReLU, then saturate to the signed output range.
  function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                               input logic [4:0] sh, input logic relu);
    logic signed [ACC_W:0] ext, rnd, r;
    ext = {acc[ACC_W-1], acc};
    rnd = '0;
    if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
    r = (ext + rnd) >>> sh;
    if (relu && r[ACC_W]) r = '0;
    if (r > SatMax)      r = SatMax;
    else if (r < SatMin) r = SatMin;
    return r[OUT_W-1:0];
  endfunction

  assign w_ext0 = {{(ACC_W-PSUM_W){bus.pe_ofm0[PSUM_W-1]}}, bus.pe_ofm0};
  assign w_ext1 = {{(ACC_W-PSUM_W){bus.pe_ofm1[PSUM_W-1]}}, bus.pe_ofm1};
  assign w_sum0 = (r_tile_cnt == 8'd0) ? w_ext0 : r_acc0 + w_ext0;
  assign w_sum1 = (r_tile_cnt == 8'd0) ? w_ext1 : r_acc1 + w_ext1;

  // Conservative room check: a same-cycle pop is not credited.
  assign w_occupancy = r_count + CntW'(r_stage_valid);
  assign w_in_ready  = (r_state == StAccum) && (w_occupancy < CntW'(FIFO_DEPTH));
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_last_tile = (r_tile_cnt == r_num_tiles - 8'd1);
  assign w_last_pix  = (r_pix_cnt == r_num_pixels - 16'd1);
  assign w_out_valid = (r_count != '0);
  assign w_push      = r_stage_valid;
  assign w_pop       = w_out_valid && bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? r_fifo_mem[r_rd_ptr] : '0;
  assign bus.busy      = (r_state != StIdle);
  assign bus.done      = r_done;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.start) w_state_next = StAccum;
      StAccum: if (w_accept && w_last_tile && w_last_pix) w_state_next = StDrain;
      StDrain: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_num_tiles   <= 8'd1;
      r_num_pixels  <= 16'd1;
      r_shift       <= '0;
      r_relu        <= 1'b0;
      r_tile_cnt    <= '0;
      r_pix_cnt     <= '0;
      r_acc0        <= '0;
      r_acc1        <= '0;
      r_stage_valid <= 1'b0;
      r_stage_data  <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_done        <= (r_state == StDrain);
      r_stage_valid <= w_accept && w_last_tile;
      if (r_state == StIdle && bus.start) begin
        r_num_tiles  <= (bus.cfg_num_tiles == 8'd0) ? 8'd1 : bus.cfg_num_tiles;
        r_num_pixels <= (bus.cfg_num_pixels == 16'd0) ? 16'd1 : bus.cfg_num_pixels;
        r_shift      <= bus.cfg_shift;
        r_relu       <= bus.cfg_relu;
        r_tile_cnt   <= '0;
        r_pix_cnt    <= '0;
      end
      if (w_accept) begin
        r_acc0 <= w_sum0;
        r_acc1 <= w_sum1;
        if (w_last_tile) begin
          r_tile_cnt   <= '0;
          r_pix_cnt    <= r_pix_cnt + 16'd1;
          r_stage_data <= {requant(w_sum1, r_shift, r_relu), requant(w_sum0, r_shift, r_relu)};
        end else begin
          r_tile_cnt <= r_tile_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= r_stage_data;
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator.
module tb_psum_accumulator;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  psum_accumulator_if #(.PSUM_W(20), .OUT_W(8)) u_if ();

  psum_accumulator #(
    .PSUM_W(20), .ACC_W(32), .OUT_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [7:0] t, input logic [15:0] p,
                          input logic [4:0] s, input logic r);
    @(negedge clk);
    u_if.cfg_num_tiles  = t;
    u_if.cfg_num_pixels = p;
    u_if.cfg_shift      = s;
    u_if.cfg_relu       = r;
    u_if.start          = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
  endtask

  // Returns at the negedge of the cycle after the accept.
  task automatic send_beat(input int a, input int b, output bit ok);
    ok = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.pe_ofm0  = 20'(a);
    u_if.pe_ofm1  = 20'(b);
    for (int i = 0; i < 200; i++) begin
      if (u_if.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    u_if.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (u_if.in_ready !== 1'b0) begin errors++;
      $display("FAIL reset_in_ready: got %b expected 0", u_if.in_ready); end
    checks++; if (u_if.out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %b expected 0", u_if.out_valid); end
    checks++; if (u_if.busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b expected 0", u_if.busy); end
    checks++; if (u_if.done !== 1'b0) begin errors++;
      $display("FAIL reset_done: got %b expected 0", u_if.done); end
    checks++; if (u_if.out_data !== 16'h0000) begin errors++;
      $display("FAIL reset_out_data: got %h expected 0000", u_if.out_data); end
  endtask

  task automatic test_accum();
    bit ok, all_ok;
    int a0 [3] = '{10, 20, 30};
    all_ok = 1'b1;
    do_start(8'd3, 16'd1, 5'd0, 1'b0);
    checks++; if (u_if.busy !== 1'b1) begin errors++;
      $display("FAIL accum_busy_after_start: got %b expected 1", u_if.busy); end
    checks++; if (u_if.in_ready !== 1'b1) begin errors++;
      $display("FAIL accum_in_ready_after_start: got %b expected 1", u_if.in_ready); end
    for (int i = 0; i < 3; i++) begin
      send_beat(a0[i], -5, ok);
      all_ok &= ok;
    end
    checks++; if (!all_ok) begin errors++;
      $display("FAIL accum_beats_accepted: got 0 expected 1"); end
    checks++; if (u_if.out_valid !== 1'b0 || u_if.done !== 1'b0) begin errors++;
      $display("FAIL accum_t1: got valid=%b done=%b expected 0 0", u_if.out_valid, u_if.done); end
    @(negedge clk);
    checks++; if (u_if.done !== 1'b1) begin errors++;
      $display("FAIL accum_done_t2: got %b expected 1", u_if.done); end
    checks++; if (u_if.busy !== 1'b0) begin errors++;
      $display("FAIL accum_busy_t2: got %b expected 0", u_if.busy); end
    checks++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== 16'hF13C) begin errors++;
      $display("FAIL accum_data: got valid=%b data=%h expected 1 f13c",
               u_if.out_valid, u_if.out_data); end
    pop_one();
    checks++; if (u_if.out_valid !== 1'b0 || u_if.done !== 1'b0) begin errors++;
      $display("FAIL accum_after_pop: got valid=%b done=%b expected 0 0",
               u_if.out_valid, u_if.done); end
  endtask

  task automatic test_round();
    bit ok;
    do_start(8'd1, 16'd1, 5'd4, 1'b0);
    send_beat(40, -24, ok);
    @(negedge clk);
    checks++; if (!ok || u_if.out_data !== 16'hFF03) begin errors++;
      $display("FAIL round_norelu: got ok=%b data=%h expected 1 ff03", ok, u_if.out_data); end
    pop_one();
    do_start(8'd1, 16'd1, 5'd4, 1'b1);
    send_beat(40, -24, ok);
    @(negedge clk);
    checks++; if (!ok || u_if.out_data !== 16'h0003) begin errors++;
      $display("FAIL round_relu: got ok=%b data=%h expected 1 0003", ok, u_if.out_data); end
    pop_one();
  endtask

  task automatic test_saturation();
    bit ok0, ok1;
    do_start(8'd2, 16'd1, 5'd0, 1'b0);
    send_beat(100, -100, ok0);
    send_beat(100, -100, ok1);
    @(negedge clk);
    checks++; if (!(ok0 && ok1) || u_if.out_data !== 16'h807F) begin errors++;
      $display("FAIL saturation: got data=%h expected 807f", u_if.out_data); end
    pop_one();
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    int rcv = 0;
    int dones = 0;
    logic [7:0] lo, hi;
    u_if.out_ready = 1'b0;
    do_start(8'd1, 16'd8, 5'd0, 1'b0);
    u_if.in_valid = 1'b1;
    repeat (12) begin
      u_if.pe_ofm0 = 20'(accepted + 1);
      u_if.pe_ofm1 = 20'(-(accepted + 1));
      if (u_if.in_ready) accepted++;
      @(negedge clk);
    end
    checks++; if (accepted != 4) begin errors++;
      $display("FAIL bp_accepted_while_stalled: got %0d expected 4", accepted); end
    checks++; if (u_if.in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_in_ready_full: got %b expected 0", u_if.in_ready); end
    checks++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== 16'hFF01) begin errors++;
      $display("FAIL bp_head_stable: got valid=%b data=%h expected 1 ff01",
               u_if.out_valid, u_if.out_data); end
    u_if.out_ready = 1'b1;
    repeat (40) begin
      u_if.in_valid = (accepted < 8);
      u_if.pe_ofm0  = 20'(accepted + 1);
      u_if.pe_ofm1  = 20'(-(accepted + 1));
      if (u_if.in_valid && u_if.in_ready) accepted++;
      if (u_if.out_valid) begin
        lo = 8'(rcv + 1);
        hi = 8'(-(rcv + 1));
        checks++; if (u_if.out_data !== {hi, lo}) begin errors++;
          $display("FAIL bp_order[%0d]: got %h expected %h", rcv, u_if.out_data, {hi, lo}); end
        rcv++;
      end
      if (u_if.done) dones++;
      @(negedge clk);
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    checks++; if (rcv != 8) begin errors++;
      $display("FAIL bp_output_count: got %0d expected 8", rcv); end
    checks++; if (dones != 1) begin errors++;
      $display("FAIL bp_done_count: got %0d expected 1", dones); end
    checks++; if (u_if.busy !== 1'b0) begin errors++;
      $display("FAIL bp_busy_end: got %b expected 0", u_if.busy); end
  endtask

  task automatic test_reset_mid_pass();
    bit ok, all_ok;
    all_ok = 1'b1;
    do_start(8'd4, 16'd1, 5'd0, 1'b0);
    send_beat(1000, 1000, ok); all_ok &= ok;
    send_beat(1000, 1000, ok); all_ok &= ok;
    reset = 1'b0;
    #1;
    checks++; if (u_if.busy !== 1'b0 || u_if.in_ready !== 1'b0) begin errors++;
      $display("FAIL midreset_idle: got busy=%b in_ready=%b expected 0 0",
               u_if.busy, u_if.in_ready); end
    checks++; if (u_if.out_valid !== 1'b0 || u_if.out_data !== 16'h0000 || u_if.done !== 1'b0)
      begin errors++;
      $display("FAIL midreset_outputs: got valid=%b data=%h done=%b expected 0 0000 0",
               u_if.out_valid, u_if.out_data, u_if.done); end
    @(negedge clk);
    reset = 1'b1;
    do_start(8'd4, 16'd1, 5'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      send_beat(i, -1, ok);
      all_ok &= ok;
    end
    @(negedge clk);
    checks++; if (!all_ok || u_if.out_data !== 16'hFC0A) begin errors++;
      $display("FAIL midreset_fresh_accum: got ok=%b data=%h expected 1 fc0a",
               all_ok, u_if.out_data); end
    pop_one();
  endtask

  task automatic test_start_busy();
    bit ok0, ok1;
    int rcv = 0;
    int dones = 0;
    logic [15:0] exp_data [2] = '{16'h0807, 16'hF709};
    do_start(8'd1, 16'd2, 5'd0, 1'b0);
    u_if.cfg_num_tiles  = 8'd3;
    u_if.cfg_num_pixels = 16'd5;
    u_if.cfg_shift      = 5'd3;
    u_if.start          = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    send_beat(7, 8, ok0);
    send_beat(9, -9, ok1);
    u_if.out_ready = 1'b1;
    repeat (10) begin
      if (u_if.out_valid) begin
        if (rcv < 2) begin
          checks++; if (u_if.out_data !== exp_data[rcv]) begin errors++;
            $display("FAIL busy_start_data[%0d]: got %h expected %h",
                     rcv, u_if.out_data, exp_data[rcv]); end
        end
        rcv++;
      end
      if (u_if.done) dones++;
      @(negedge clk);
    end
    u_if.out_ready = 1'b0;
    checks++; if (!(ok0 && ok1) || rcv != 2) begin errors++;
      $display("FAIL busy_start_pixels: got %0d expected 2", rcv); end
    checks++; if (dones != 1 || u_if.busy !== 1'b0) begin errors++;
      $display("FAIL busy_start_done: got dones=%0d busy=%b expected 1 0", dones, u_if.busy); end
  endtask

  task automatic test_cfg_zero();
    bit ok;
    do_start(8'd0, 16'd0, 5'd0, 1'b0);
    send_beat(5, -3, ok);
    @(negedge clk);
    checks++; if (!ok || u_if.out_data !== 16'hFD05 || u_if.done !== 1'b1) begin errors++;
      $display("FAIL cfg_zero: got data=%h done=%b expected fd05 1", u_if.out_data, u_if.done); end
    pop_one();
    checks++; if (u_if.busy !== 1'b0 || u_if.out_valid !== 1'b0) begin errors++;
      $display("FAIL cfg_zero_end: got busy=%b valid=%b expected 0 0",
               u_if.busy, u_if.out_valid); end
  endtask

  initial begin
    reset               = 1'b0;
    u_if.start          = 1'b0;
    u_if.cfg_num_tiles  = '0;
    u_if.cfg_num_pixels = '0;
    u_if.cfg_shift      = '0;
    u_if.cfg_relu       = 1'b0;
    u_if.in_valid       = 1'b0;
    u_if.pe_ofm0        = '0;
    u_if.pe_ofm1        = '0;
    u_if.out_ready      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_accum();
    test_round();
    test_saturation();
    test_backpressure();
    test_reset_mid_pass();
    test_start_busy();
    test_cfg_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
